ws2812_transmissor: RTL and testbench
=====================================

// Module: ws2812_transmissor
// PURPOSE
//  Serial transmitter for a WS2812-style addressable LED strip. The colour mixer
//  maps an index to a 24-bit RGB colour on cor_led; this block drives that index.
//  It streams NUM_LEDS pixels as single-wire NRZ pulse-width bits, then holds the
//  line low for the latch/reset gap. It sits between the colour logic and the strip pin.
// PARAMETERS
//  N         10    width of led_idx (matches the colour mixer index width)
//  NUM_LEDS  16    pixels per frame, 1..2^N
//  TBIT      63    clock cycles per bit (1.25us @ 50MHz)
//  T0H       20    high cycles for a '0' bit, 0 < T0H < T1H < TBIT
//  T1H       40    high cycles for a '1' bit
//  TRESET    3000  low cycles after the last bit (60us @ 50MHz)
// PORTS
//  clock    in   1   single clock; all logic on the rising edge
//  reset_n  in   1   synchronous reset, active low
//  start    in   1   frame request; sampled only in IDLE
//  cor_led  in   24  {R,G,B} colour of pixel led_idx; must be valid 1 cycle after led_idx changes
//  led_idx  out  N   index of the pixel being fetched, 0..NUM_LEDS-1
//  dout     out  1   strip data line, registered
//  busy     out  1   high from the cycle after start is accepted until done
//  done     out  1   one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset (reset_n=0 at edge): dout=0, busy=0, done=0, led_idx=0, state IDLE, all counters 0.
//   Applies mid-frame too: the line drops low immediately, no done pulse is given,
//   and the partial frame is abandoned.
//  FSM: IDLE -> LOAD -> BITS -> GAP -> IDLE.
//  IDLE:  led_idx=0, dout=0. start=1 at edge t -> LOAD at t+1, busy=1.
//  LOAD:  lasts 1 cycle. At edge t+2, cor_led is captured into a 24-bit shift register
//         reordered to wire order {G,R,B}, MSB first. bit_cnt=23, phase=0 -> BITS.
//  BITS:  phase counts 0..TBIT-1. The registered dout is high while
//         phase < (cur_bit ? T1H : T0H), otherwise low.
//   - First high cycle of the frame is t+2.
//   - Each bit lasts exactly TBIT cycles.
//   - At phase==TBIT-1: if bit_cnt>0, shift left and decrement bit_cnt.
//   - Prefetch: during the last bit of a pixel (bit_cnt==0), led_idx = pixel+1 from
//     phase 0. cor_led is captured into a holding register at phase==TBIT-2.
//     At phase==TBIT-1 the holding register loads the shift register.
//     The bit stream is therefore continuous, with no inter-pixel gap.
//   - On the last bit of pixel NUM_LEDS-1, there is no prefetch (led_idx holds) -> GAP.
//  GAP:   dout=0 for exactly TRESET cycles. In the cycle after the gap: done=1, busy=0,
//         led_idx=0, state IDLE.
//   - A start in that same cycle is accepted (back-to-back frames).
//  start while busy=1 is ignored; it is not queued.
//  Counters: phase is ceil(log2(TBIT)) bits, gap is ceil(log2(TRESET+1)) bits,
//   pixel counter is N bits. None wrap: each is reset on state entry.
//  NUM_LEDS=1: there is no prefetch; LED0 goes directly to GAP.
//  cor_led is never sampled outside LOAD or the prefetch cycle; changes elsewhere
//   have no effect.
// TESTING (bench params: NUM_LEDS=2, TBIT=10, T0H=3, T1H=6, TRESET=20)
//  1. reset_n=0 for 2 cycles, start=1 -> dout=0, busy=0, done=0, led_idx=0 throughout.
//  2. NUM_LEDS=1, cor_led=24'hFF0000, start pulse at t -> busy=1 from t+1.
//     Expect 8 bits of '0' (3-high/7-low), then 8 bits of '1' (6-high/4-low),
//     then 8 bits of '0'. First rise at t+2; 240 cycles of bits in total.
//  3. Mixer model returns idx0=24'h00FF00, idx1=24'h0000FF -> 48 bits, period 10, no gap.
//     First 8 bits are '1', next 40 are '0' except bits 40..47, which are '1'.
//     led_idx goes 0->1 at the start of bit 23.
//  4. After the last bit: dout low exactly 20 cycles, then done=1 for 1 cycle with busy=0.
//     start held high -> the next frame's first rise is 2 cycles after the done cycle.
//  5. start pulsed at bit 10 of a frame -> ignored; exactly one done pulse.
//  6. reset_n=0 at phase 2 of a '1' bit (dout high) -> dout=0, busy=0 the next cycle;
//     no done pulse; a new start after release gives a full, correct frame.

Source files
------------

// File: rtl/ws2812_transmissor.sv
// ws2812_transmissor
//   Serial transmitter for a WS2812-style LED strip. It walks the pixel index
//   led_idx through 0..NUM_LEDS-1, pulls each 24-bit {R,G,B} colour from the
//   colour mixer on cor_led and streams it MSB first in wire order {G,R,B} as
//   NRZ pulse-width bits. After the last pixel the line is held low for the
//   latch gap, and then a single done pulse is given.
//
// Ports
//   clock    in   1   rising-edge clock
//   reset_n  in   1   synchronous reset, active low
//   start    in   1   frame request, only looked at while idle
//   cor_led  in  24   {R,G,B} colour of pixel led_idx, valid 1 cycle after
//                     led_idx changes
//   led_idx  out  N   pixel currently being fetched
//   dout     out  1   strip data line (registered)
//   busy     out  1   frame in progress
//   done     out  1   one-cycle pulse after the latch gap
module ws2812_transmissor #(
  parameter int unsigned N        = 10,
  parameter int unsigned NUM_LEDS = 16,
  parameter int unsigned TBIT     = 63,
  parameter int unsigned T0H      = 20,
  parameter int unsigned T1H      = 40,
  parameter int unsigned TRESET   = 3000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [23:0]  cor_led,
  output logic [N-1:0] led_idx,
  output logic         dout,
  output logic         busy,
  output logic         done
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int unsigned PW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int unsigned GW = (TRESET > 0) ? $clog2(TRESET + 1) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(TBIT - 1);
  localparam logic [PW-1:0] PH_FETCH = PW'(TBIT - 2);
  localparam logic [PW-1:0] HIGH_0   = PW'(T0H);
  localparam logic [PW-1:0] HIGH_1   = PW'(T1H);
  localparam logic [GW-1:0] GAP_LAST = GW'(TRESET - 1);
  localparam logic [N-1:0]  PIX_LAST = N'(NUM_LEDS - 1);
  localparam logic [4:0]    BIT_TOP  = 5'd23;

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BITS = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  generate
    if (NUM_LEDS < 1 || NUM_LEDS > (1 << N)) begin : g_bad_num_leds
      $error("ws2812_transmissor: NUM_LEDS must be in 1..2^N");
    end
    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
      $error("ws2812_transmissor: need 0 < T0H < T1H < TBIT");
    end
    if (TRESET < 1) begin : g_bad_reset_gap
      $error("ws2812_transmissor: TRESET must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic [GW-1:0] gap_cnt;
  logic [N-1:0]  pixel;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;
  logic [23:0]   hold;

  // Next-state values
  logic [1:0]    state_n;
  logic [PW-1:0] phase_n;
  logic [GW-1:0] gap_n;
  logic [N-1:0]  pixel_n;
  logic [4:0]    bit_cnt_n;
  logic [23:0]   shreg_n;
  logic [23:0]   hold_n;
  logic          dout_n;
  logic          busy_n;
  logic          done_n;

  logic          prefetch;
  logic          last_pixel;
  logic [PW-1:0] high_len;

  // {R,G,B} from the mixer becomes {G,R,B} on the wire.
  function automatic logic [23:0] wire_order(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  assign last_pixel = (pixel == PIX_LAST);

  // During the final bit of every pixel except the last, the next pixel's
  // index is already presented so its colour has settled by PH_FETCH.
  assign prefetch = (state == ST_BITS) && (bit_cnt == '0) && !last_pixel;

  assign led_idx  = prefetch ? pixel + N'(1) : pixel;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    gap_n     = gap_cnt;
    pixel_n   = pixel;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    hold_n    = hold;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        pixel_n = '0;
        busy_n  = 1'b0;
        if (start) begin
          state_n = ST_LOAD;
          busy_n  = 1'b1;
        end
      end

      ST_LOAD: begin
        shreg_n   = wire_order(cor_led);
        bit_cnt_n = BIT_TOP;
        phase_n   = '0;
        state_n   = ST_BITS;
      end

      ST_BITS: begin
        if (prefetch && (phase == PH_FETCH)) begin
          hold_n = wire_order(cor_led);
        end

        if (phase == PH_LAST) begin
          phase_n = '0;
          if (bit_cnt != '0) begin
            shreg_n   = {shreg[22:0], 1'b0};
            bit_cnt_n = bit_cnt - 5'd1;
          end else if (!last_pixel) begin
            // Prefetched pixel follows with no gap in the bit stream.
            shreg_n   = hold;
            bit_cnt_n = BIT_TOP;
            pixel_n   = pixel + N'(1);
          end else begin
            state_n = ST_GAP;
            gap_n   = '0;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pixel_n = '0;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        pixel_n = '0;
      end
    endcase

    // dout is computed from the upcoming bit and phase so that the registered
    // line rises in the very first BITS cycle rather than one cycle late.
    high_len = shreg_n[23] ? HIGH_1 : HIGH_0;
    dout_n   = (state_n == ST_BITS) && (phase_n < high_len);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      phase   <= '0;
      gap_cnt <= '0;
      pixel   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      hold    <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      gap_cnt <= gap_n;
      pixel   <= pixel_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      hold    <= hold_n;
      dout    <= dout_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_ws2812_transmissor.sv
// Bench for ws2812_transmissor: a 2-pixel instance fed by a mixer model and a
// 1-pixel instance fed directly. Expected line waveforms are built from the
// pixel colours by the bit-timing rules.
module tb_ws2812_transmissor;

  localparam int TBIT   = 10;
  localparam int T0H    = 3;
  localparam int T1H    = 6;
  localparam int TRESET = 20;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [23:0] cor_a, cor_b;
  logic [9:0]  idx_a, idx_b;
  logic        dout_a, dout_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [2];
  logic [9:0]  prev_idx = '0;

  always #5 clock = ~clock;

  ws2812_transmissor #(
    .N(10), .NUM_LEDS(2), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .cor_led(cor_a),
    .led_idx(idx_a), .dout(dout_a), .busy(busy_a), .done(done_a)
  );

  ws2812_transmissor #(
    .N(10), .NUM_LEDS(1), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .cor_led(cor_b),
    .led_idx(idx_b), .dout(dout_b), .busy(busy_b), .done(done_b)
  );

  // Mixer model: garbage in the cycle right after the index moves, the stored
  // colour once the index has been stable for a cycle.
  always @(negedge clock) begin
    if (idx_a != prev_idx || idx_a > 10'd1) cor_a = 24'($urandom);
    else cor_a = mem[idx_a[0]];
    prev_idx = idx_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("idle dout", 32'(dout_a), 32'd0);
      check("idle busy", 32'(busy_a), 32'd0);
      check("idle done", 32'(done_a), 32'd0);
      check("idle idx",  32'(idx_a),  32'd0);
    end
  endtask

  // Runs one frame on instance sel (0: 2-pixel, 1: 1-pixel). start is raised
  // at the current negedge. pulse_k raises start for one cycle mid-frame,
  // abort_k asserts reset after the check at that cycle.
  task automatic frame(input int sel, input logic [23:0] c0, input logic [23:0] c1,
                       input bit keep_start, input int pulse_k, input int abort_k);
    int          nl, len, kd, j, b, p;
    bit          wave[$];
    logic [23:0] cols [2];
    logic [23:0] g;
    logic        e_d, e_b, e_dn;
    logic [9:0]  e_i;
    logic        o_d, o_b, o_dn;
    logic [9:0]  o_i;
    bit          bv;

    nl = (sel != 0) ? 1 : 2;
    cols[0] = c0;
    cols[1] = c1;
    if (sel != 0) cor_b = c0;
    else begin
      mem[0] = c0;
      mem[1] = c1;
    end

    for (int px = 0; px < nl; px++) begin
      g = {cols[px][15:8], cols[px][23:16], cols[px][7:0]};
      for (int i = 23; i >= 0; i--) begin
        bv = g[i];
        for (int ph = 0; ph < TBIT; ph++) wave.push_back(ph < (bv ? T1H : T0H));
      end
    end
    for (int i = 0; i < TRESET; i++) wave.push_back(1'b0);

    len = nl * 24 * TBIT;
    kd  = 2 + len + TRESET;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;

    for (int k = 1; k <= kd; k++) begin
      @(negedge clock);
      if (k == 1) begin
        e_d = 1'b0; e_b = 1'b1; e_dn = 1'b0; e_i = '0;
      end else if (k < kd) begin
        j = k - 2;
        e_d = wave[j]; e_b = 1'b1; e_dn = 1'b0;
        if (j < len) begin
          b = j / TBIT;
          p = b / 24;
          e_i = ((b % 24) == 23 && p < nl - 1) ? 10'(p + 1) : 10'(p);
        end else begin
          e_i = 10'(nl - 1);
        end
      end else begin
        e_d = 1'b0; e_b = 1'b0; e_dn = 1'b1; e_i = '0;
      end

      o_d  = (sel != 0) ? dout_b : dout_a;
      o_b  = (sel != 0) ? busy_b : busy_a;
      o_dn = (sel != 0) ? done_b : done_a;
      o_i  = (sel != 0) ? idx_b  : idx_a;
      check($sformatf("dout k=%0d", k), 32'(o_d),  32'(e_d));
      check($sformatf("busy k=%0d", k), 32'(o_b),  32'(e_b));
      check($sformatf("done k=%0d", k), 32'(o_dn), 32'(e_dn));
      check($sformatf("idx k=%0d", k),  32'(o_i),  32'(e_i));

      if (k == abort_k) begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clock);
        check("abort dout", 32'(o_d_now(sel)), 32'd0);
        check("abort busy", 32'((sel != 0) ? busy_b : busy_a), 32'd0);
        check("abort done", 32'((sel != 0) ? done_b : done_a), 32'd0);
        check("abort idx",  32'((sel != 0) ? idx_b : idx_a),   32'd0);
        reset_n = 1'b1;
        return;
      end

      if (sel != 0) start_b = keep_start || (k == pulse_k);
      else          start_a = keep_start || (k == pulse_k);
    end
  endtask

  function automatic logic o_d_now(input int sel);
    return (sel != 0) ? dout_b : dout_a;
  endfunction

  initial begin
    bit ks;

    reset_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    cor_b   = '0;
    mem[0]  = '0;
    mem[1]  = '0;

    // Reset held with start high: everything stays quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst dout_a", 32'(dout_a), 32'd0);
      check("rst busy_a", 32'(busy_a), 32'd0);
      check("rst done_a", 32'(done_a), 32'd0);
      check("rst idx_a",  32'(idx_a),  32'd0);
      check("rst dout_b", 32'(dout_b), 32'd0);
      check("rst busy_b", 32'(busy_b), 32'd0);
      check("rst done_b", 32'(done_b), 32'd0);
    end
    reset_n = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    check_quiet_a(3);

    // Single pixel, red only.
    @(negedge clock);
    frame(1, 24'hFF0000, 24'h000000, 1'b0, -1, -1);

    // Two pixels with prefetch; start held through the frame and into the
    // done cycle so the next frame runs back to back.
    @(negedge clock);
    frame(0, 24'h00FF00, 24'h0000FF, 1'b1, -1, -1);
    frame(0, 24'($urandom), 24'($urandom), 1'b0, -1, -1);
    check_quiet_a(5);

    // start pulsed at bit 10 is ignored: one done, then silence.
    @(negedge clock);
    frame(0, 24'($urandom), 24'($urandom), 1'b0, 2 + 10 * TBIT, -1);
    check_quiet_a(30);

    // Reset at phase 2 of a '1' bit (MSB of green set).
    @(negedge clock);
    frame(0, 24'($urandom) | 24'h008000, 24'($urandom), 1'b0, -1, 4);
    check_quiet_a(4);
    @(negedge clock);
    frame(0, 24'($urandom), 24'($urandom), 1'b0, -1, -1);

    // Randomised frames, sometimes chained.
    ks = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!ks) begin
        check_quiet_a(int'($urandom_range(1, 6)));
        @(negedge clock);
      end
      ks = (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame(0, 24'($urandom), 24'($urandom), ks, -1, -1);
    end
    check_quiet_a(3);

    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      frame(1, 24'($urandom), 24'h000000, 1'b0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
